adc_avg_ctrl: RTL and testbench

Capture sequencer for the pipelined ADC model. On a start request it discards the samples still in flight in the ADC pipeline, then accumulates a programmable power-of-two number of signed ADC codes and presents their floor average, with an overflow count, through a valid/ready result port. It sits between the ADC model output and the downstream solver/checker logic that consumes averaged measurements.

---
 rtl/adc_avg_ctrl.sv | 172 +++++++++++++++++
 tb/tb_adc_avg_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_avg_ctrl.sv
// adc_avg_ctrl: capture sequencer for the pipelined ADC model.
//
// On an accepted start the block first lets the samples already in flight in the ADC
// pipeline drain (FLUSH). It then accumulates 2^n signed codes (ACC) and presents their
// floor average plus the number of overflow-flagged samples on a valid/ready port (DONE).
//
// Ports:
//   clk_i            clock shared with the ADC
//   rst_ni           synchronous active-low reset
//   start_i          capture request, accepted only when idle
//   abort_i          cancel a capture in FLUSH/ACC
//   avg_log2_i       averaging exponent, clamped to LOG2_MAX_AVG, latched on start
//   adc_code_i       two's-complement ADC output code
//   adc_ovfl_pos_i   ADC positive-overflow flag, aligned with the ADC input
//   adc_ovfl_neg_i   ADC negative-overflow flag, aligned with the ADC input
//   busy_o           capture in progress or result pending
//   result_o         signed floor average of the captured codes
//   ovfl_cnt_o       number of captured samples with either overflow flag set
//   result_valid_o   result_o/ovfl_cnt_o valid
//   result_ready_i   consumer accepts the result
module adc_avg_ctrl #(
    parameter int unsigned BITS         = 8,
    parameter int unsigned PIPE         = 5,
    parameter int unsigned LOG2_MAX_AVG = 4,
    parameter int unsigned AW           = $clog2(LOG2_MAX_AVG + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [AW-1:0]           avg_log2_i,
    input  logic [BITS-1:0]         adc_code_i,
    input  logic                    adc_ovfl_pos_i,
    input  logic                    adc_ovfl_neg_i,
    output logic                    busy_o,
    output logic [BITS-1:0]         result_o,
    output logic [LOG2_MAX_AVG:0]   ovfl_cnt_o,
    output logic                    result_valid_o,
    input  logic                    result_ready_i
);

    localparam int unsigned ACW = BITS + LOG2_MAX_AVG;
    localparam int unsigned FW  = $clog2(PIPE);
    localparam int unsigned CW  = LOG2_MAX_AVG;

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StAcc,
        StDone
    } state_e;

    state_e                   state_q, state_d;
    logic [AW-1:0]            n_q, n_d;
    logic [FW-1:0]            flush_cnt_q, flush_cnt_d;
    logic [CW-1:0]            smp_cnt_q, smp_cnt_d;
    logic signed [ACW-1:0]    acc_q, acc_d;
    logic [LOG2_MAX_AVG:0]    ovfl_acc_q, ovfl_acc_d;
    logic [BITS-1:0]          result_q, result_d;
    logic [LOG2_MAX_AVG:0]    ovfl_cnt_q, ovfl_cnt_d;
    logic [PIPE-1:0]          pos_dly_q, pos_dly_d;
    logic [PIPE-1:0]          neg_dly_q, neg_dly_d;

    logic                     flag_aligned;
    logic signed [ACW-1:0]    code_ext;
    logic signed [ACW-1:0]    acc_next;
    logic [LOG2_MAX_AVG:0]    ovfl_next;
    logic [AW-1:0]            n_clamped;

    // The flags leave the ADC input PIPE cycles before the matching code appears, so
    // they ride a delay line of the same depth; it runs in every state so the
    // alignment is already correct on the first ACC cycle.
    assign pos_dly_d    = {pos_dly_q[PIPE-2:0], adc_ovfl_pos_i};
    assign neg_dly_d    = {neg_dly_q[PIPE-2:0], adc_ovfl_neg_i};
    assign flag_aligned = pos_dly_q[PIPE-1] | neg_dly_q[PIPE-1];

    assign code_ext  = {{LOG2_MAX_AVG{adc_code_i[BITS-1]}}, adc_code_i};
    assign acc_next  = acc_q + code_ext;
    assign ovfl_next = ovfl_acc_q + {{LOG2_MAX_AVG{1'b0}}, flag_aligned};
    assign n_clamped = (avg_log2_i > AW'(LOG2_MAX_AVG)) ? AW'(LOG2_MAX_AVG) : avg_log2_i;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        flush_cnt_d = flush_cnt_q;
        smp_cnt_d   = smp_cnt_q;
        acc_d       = acc_q;
        ovfl_acc_d  = ovfl_acc_q;
        result_d    = result_q;
        ovfl_cnt_d  = ovfl_cnt_q;

        case (state_q)
            StIdle: begin
                // start together with abort is treated as no request
                if (start_i && !abort_i) begin
                    n_d         = n_clamped;
                    acc_d       = '0;
                    ovfl_acc_d  = '0;
                    flush_cnt_d = FW'(PIPE - 1);
                    state_d     = StFlush;
                end
            end
            StFlush: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (flush_cnt_q == '0) begin
                    // 2^n - 1 without a wider intermediate; n == CW yields all ones
                    smp_cnt_d = ~({CW{1'b1}} << n_q);
                    state_d   = StAcc;
                end else begin
                    flush_cnt_d = flush_cnt_q - FW'(1);
                end
            end
            StAcc: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else begin
                    acc_d      = acc_next;
                    ovfl_acc_d = ovfl_next;
                    if (smp_cnt_q == '0) begin
                        // arithmetic shift gives the floor average
                        result_d   = BITS'(acc_next >>> n_q);
                        ovfl_cnt_d = ovfl_next;
                        state_d    = StDone;
                    end else begin
                        smp_cnt_d = smp_cnt_q - CW'(1);
                    end
                end
            end
            StDone: begin
                if (result_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            n_q         <= '0;
            flush_cnt_q <= '0;
            smp_cnt_q   <= '0;
            acc_q       <= '0;
            ovfl_acc_q  <= '0;
            result_q    <= '0;
            ovfl_cnt_q  <= '0;
            pos_dly_q   <= '0;
            neg_dly_q   <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            flush_cnt_q <= flush_cnt_d;
            smp_cnt_q   <= smp_cnt_d;
            acc_q       <= acc_d;
            ovfl_acc_q  <= ovfl_acc_d;
            result_q    <= result_d;
            ovfl_cnt_q  <= ovfl_cnt_d;
            pos_dly_q   <= pos_dly_d;
            neg_dly_q   <= neg_dly_d;
        end
    end

    assign busy_o         = (state_q != StIdle);
    assign result_valid_o = (state_q == StDone);
    assign result_o       = result_q;
    assign ovfl_cnt_o     = ovfl_cnt_q;

endmodule

// File: tb/tb_adc_avg_ctrl.sv
// tb_adc_avg_ctrl: scoreboard bench for adc_avg_ctrl.
//
// A small ADC stand-in delays an ideal code by PIPE cycles while passing the overflow
// flags straight through. Directed captures push their hand-computed result, overflow
// count and expected valid cycle into a queue; a monitor on the falling edge pops and
// compares on every result transfer and also watches latency, stability and pulse width.
module tb_adc_avg_ctrl;

    localparam int BITS = 8;
    localparam int PIPE = 5;
    localparam int LMAX = 4;
    localparam int AW   = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            abort;
    logic [AW-1:0]   avg_log2;
    logic [BITS-1:0] adc_code;
    logic            adc_ovfl_pos;
    logic            adc_ovfl_neg;
    logic            busy;
    logic [BITS-1:0] result;
    logic [LMAX:0]   ovfl_cnt;
    logic            result_valid;
    logic            result_ready;

    always #5 clk = ~clk;

    adc_avg_ctrl #(
        .BITS         (BITS),
        .PIPE         (PIPE),
        .LOG2_MAX_AVG (LMAX),
        .AW           (AW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .abort_i        (abort),
        .avg_log2_i     (avg_log2),
        .adc_code_i     (adc_code),
        .adc_ovfl_pos_i (adc_ovfl_pos),
        .adc_ovfl_neg_i (adc_ovfl_neg),
        .busy_o         (busy),
        .result_o       (result),
        .ovfl_cnt_o     (ovfl_cnt),
        .result_valid_o (result_valid),
        .result_ready_i (result_ready)
    );

    // ADC stand-in: code delayed PIPE cycles, flags undelayed
    logic [BITS-1:0] ain_code;
    logic [BITS-1:0] alt_b;
    logic            ain_pos;
    logic            ain_neg;
    logic            alt_en = 1'b0;
    logic            phase  = 1'b0;
    logic [BITS-1:0] code_pipe [PIPE];

    always @(posedge clk) begin
        phase        <= ~phase;
        code_pipe[0] <= (alt_en && phase) ? alt_b : ain_code;
        for (int i = 1; i < PIPE; i++) code_pipe[i] <= code_pipe[i-1];
    end
    assign adc_code     = code_pipe[PIPE-1];
    assign adc_ovfl_pos = ain_pos;
    assign adc_ovfl_neg = ain_neg;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [BITS-1:0] res;
        logic [LMAX:0]   ovf;
        int              vcyc;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    // Monitor
    logic            prev_valid = 1'b0;
    logic            prev_ready = 1'b0;
    logic [BITS-1:0] prev_res   = '0;
    logic [LMAX:0]   prev_ovf   = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (result_valid && !prev_valid) begin
                if (exp_q.size() == 0) check("unexpected_valid", 32'(result_valid), 32'd0);
                else check("valid_latency", 32'(cyc), 32'(exp_q[0].vcyc));
            end
            if (result_valid && prev_valid) begin
                check("hold_result", 32'(result), 32'(prev_res));
                check("hold_ovfl", 32'(ovfl_cnt), 32'(prev_ovf));
            end
            if (prev_valid && prev_ready) check("valid_drop", 32'(result_valid), 32'd0);
            if (result_valid && result_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("ovfl_cnt", 32'(ovfl_cnt), 32'(e.ovf));
            end
        end
        prev_valid = result_valid;
        prev_ready = result_ready;
        prev_res   = result;
        prev_ovf   = ovfl_cnt;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [BITS-1:0] code, input logic pos, input logic neg);
        ain_code = code;
        ain_pos  = pos;
        ain_neg  = neg;
        alt_en   = 1'b0;
        tick(PIPE + 2);
    endtask

    task automatic set_alt(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        ain_code = a;
        alt_b    = b;
        ain_pos  = 1'b0;
        ain_neg  = 1'b0;
        alt_en   = 1'b1;
        tick(PIPE + 2);
    endtask

    // Issue a start; when a result is expected, queue it with its valid cycle.
    task automatic launch(input logic [AW-1:0] avg, input bit want, input logic [BITS-1:0] res,
                          input logic [LMAX:0] ovf, input int nsamp, input bit zero_after);
        exp_t e;
        avg_log2 = avg;
        start    = 1'b1;
        tick(1);
        start = 1'b0;
        if (zero_after) begin
            ain_code = '0;
            ain_pos  = 1'b0;
            ain_neg  = 1'b0;
        end
        if (want) begin
            e.res  = res;
            e.ovf  = ovf;
            e.vcyc = cyc + PIPE + nsamp;
            exp_q.push_back(e);
        end
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 64) begin
            tick(1);
            k++;
        end
        if (busy) check({name, "_timeout"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        avg_log2     = '0;
        result_ready = 1'b1;
        ain_code     = '0;
        alt_b        = '0;
        ain_pos      = 1'b0;
        ain_neg      = 1'b0;
        tick(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_ovfl", 32'(ovfl_cnt), 32'd0);
        rst_n = 1'b1;

        // 0.25 -> code 0x40, 4 samples, valid 9 cycles after start
        set_in(8'h40, 1'b0, 1'b0);
        launch(3'd2, 1'b1, 8'h40, 5'd0, 4, 1'b0);
        wait_idle("quarter");

        // +0.6 clips at 0x7F with positive flag; -0.6 clips at 0x80 with negative flag
        set_in(8'h7F, 1'b1, 1'b0);
        launch(3'd2, 1'b1, 8'h7F, 5'd4, 4, 1'b0);
        wait_idle("pos_ovfl");
        set_in(8'h80, 1'b0, 1'b1);
        launch(3'd2, 1'b1, 8'h80, 5'd4, 4, 1'b0);
        wait_idle("neg_ovfl");

        // input drops from 0.6 to 0.0 right after the start edge: flushed flags ignored
        set_in(8'h7F, 1'b1, 1'b0);
        launch(3'd2, 1'b1, 8'h00, 5'd0, 4, 1'b1);
        wait_idle("switch");

        // -0.1 -> code -26 (0xE6), 8 samples
        set_in(8'hE6, 1'b0, 1'b0);
        launch(3'd3, 1'b1, 8'hE6, 5'd0, 8, 1'b0);
        wait_idle("neg_tenth");

        // floor averaging: (1+2)/2 -> 1, (-1-2)/2 -> -2
        set_alt(8'h01, 8'h02);
        launch(3'd1, 1'b1, 8'h01, 5'd0, 2, 1'b0);
        wait_idle("alt_pos");
        set_alt(8'hFF, 8'hFE);
        launch(3'd1, 1'b1, 8'hFE, 5'd0, 2, 1'b0);
        wait_idle("alt_neg");

        // exponent 7 clamps to 16 samples, valid 21 cycles after start
        set_in(8'h0A, 1'b0, 1'b0);
        launch(3'd7, 1'b1, 8'h0A, 5'd0, 16, 1'b0);
        wait_idle("clamp");

        // single-sample capture
        set_in(8'hF3, 1'b0, 1'b0);
        launch(3'd0, 1'b1, 8'hF3, 5'd0, 1, 1'b0);
        wait_idle("single");

        // consumer stalls 10 cycles in DONE; start pulses must be ignored
        set_in(8'h40, 1'b0, 1'b0);
        result_ready = 1'b0;
        launch(3'd2, 1'b1, 8'h40, 5'd0, 4, 1'b0);
        begin
            int k = 0;
            while (!result_valid && k < 40) begin
                tick(1);
                k++;
            end
            if (!result_valid) check("stall_valid_timeout", 32'(result_valid), 32'd1);
        end
        for (int i = 0; i < 10; i++) begin
            start = ~start;
            tick(1);
            check("stall_busy", 32'(busy), 32'd1);
        end
        start        = 1'b0;
        result_ready = 1'b1;
        tick(1);
        check("release_busy", 32'(busy), 32'd0);
        check("release_valid", 32'(result_valid), 32'd0);

        // abort on the third ACC sample: idle next cycle, no result ever
        launch(3'd2, 1'b0, 8'h00, 5'd0, 4, 1'b0);
        tick(PIPE + 2);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        tick(20);
        check("abort_no_valid", 32'(result_valid), 32'd0);

        // reset during FLUSH clears every output
        launch(3'd2, 1'b0, 8'h00, 5'd0, 4, 1'b0);
        tick(1);
        rst_n = 1'b0;
        tick(1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(result_valid), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_ovfl", 32'(ovfl_cnt), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // start with abort in IDLE is not a request
        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", 32'(busy), 32'd0);
        tick(PIPE + 8);
        check("start_abort_no_valid", 32'(result_valid), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
